// File: rtl/bb8051_defines.sv
// Shared encodings for the 8051 operand-fetch datapath: ALU source selects,
// operand addressing modes and the fetch FSM states.
package bb8051_defines;

    typedef enum logic [1:0] {
        SRC_SEL_NO       = 2'd0,
        SRC_SEL_ACC      = 2'd1,
        SRC_SEL_CONSTANT = 2'd2
    } src_sel_e;

    localparam logic [2:0] OPND_MODE_NONE = 3'd0;
    localparam logic [2:0] OPND_MODE_ACC  = 3'd1;
    localparam logic [2:0] OPND_MODE_IMM  = 3'd2;
    localparam logic [2:0] OPND_MODE_DIR  = 3'd3;
    localparam logic [2:0] OPND_MODE_RN   = 3'd4;
    localparam logic [2:0] OPND_MODE_IND  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_GO   = 2'd3
    } fetch_state_e;

    function automatic logic mode_needs_ram(input logic [2:0] mode);
        return (mode == OPND_MODE_DIR) || (mode == OPND_MODE_RN) || (mode == OPND_MODE_IND);
    endfunction

    function automatic logic mode_reserved(input logic [2:0] mode);
        return mode[2] & mode[1];
    endfunction

    // Select code for operands that resolve without touching RAM.
    function automatic src_sel_e direct_sel(input logic [2:0] mode);
        case (mode)
            OPND_MODE_ACC: return SRC_SEL_ACC;
            OPND_MODE_IMM: return SRC_SEL_CONSTANT;
            default:       return SRC_SEL_NO;
        endcase
    endfunction

endpackage

// File: rtl/bb8051_opnd_addr_gen.sv
// Internal-RAM address for one operand: direct byte, banked Rn, or the two
// phases of @Ri (register fetch, then the returned pointer).
module bb8051_opnd_addr_gen
    import bb8051_defines::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic [2:0]        mode,
    input  logic [7:0]        op,
    input  logic [1:0]        bank,
    input  logic [DATA_W-1:0] pointer,
    input  logic              ind_ph,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              needs_ram
);

    always_comb begin
        ram_addr  = '0;
        needs_ram = mode_needs_ram(mode);
        case (mode)
            OPND_MODE_DIR: ram_addr = ADDR_W'(op);
            OPND_MODE_RN:  ram_addr = ADDR_W'({bank, op[2:0]});
            OPND_MODE_IND: ram_addr = ind_ph ? ADDR_W'(pointer)
                                             : ADDR_W'({bank, 2'b00, op[0]});
            default:       ram_addr = '0;
        endcase
    end

endmodule

// File: rtl/bb8051_opnd_fetch_ctrl.sv
// Operand fetch sequencer: resolves src1/src2 for an ALU instruction, issuing
// internal-RAM reads as needed, then pulses alu_go for one cycle.
module bb8051_opnd_fetch_ctrl
    import bb8051_defines::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        mode1,
    input  logic [2:0]        mode2,
    input  logic [7:0]        op1_in,
    input  logic [7:0]        op2_in,
    input  logic [1:0]        reg_bank,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output src_sel_e          src1_sel,
    output src_sel_e          src2_sel,
    output logic [DATA_W-1:0] src1_data,
    output logic [DATA_W-1:0] src2_data,
    output logic              alu_go,
    output logic              mode_err
);

    fetch_state_e      state_q, state_d;
    logic              cur_op_q, cur_op_d;   // 0: operand 1, 1: operand 2
    logic              ind_ph_q, ind_ph_d;
    logic [2:0]        mode1_q, mode1_d, mode2_q, mode2_d;
    logic [7:0]        op1_q, op1_d, op2_q, op2_d;
    logic [1:0]        bank_q, bank_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    src_sel_e          sel1_q, sel1_d, sel2_q, sel2_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;

    logic              idle;
    logic [2:0]        g1_mode, g2_mode;
    logic [7:0]        g1_op, g2_op;
    logic [1:0]        g_bank;
    logic              g1_ph, g2_ph;
    logic [ADDR_W-1:0] g1_addr, g2_addr;
    logic              g1_need, g2_need;

    // While idle the generators see the live request so the first read
    // address is ready at the accepting edge.
    assign idle    = (state_q == ST_IDLE);
    assign g1_mode = idle ? mode1    : mode1_q;
    assign g2_mode = idle ? mode2    : mode2_q;
    assign g1_op   = idle ? op1_in   : op1_q;
    assign g2_op   = idle ? op2_in   : op2_q;
    assign g_bank  = idle ? reg_bank : bank_q;
    assign g1_ph   = (state_q == ST_CAP) && !cur_op_q && !ind_ph_q;
    assign g2_ph   = (state_q == ST_CAP) &&  cur_op_q && !ind_ph_q;

    bb8051_opnd_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_gen1 (
        .mode      (g1_mode),
        .op        (g1_op),
        .bank      (g_bank),
        .pointer   (ram_rdata),
        .ind_ph    (g1_ph),
        .ram_addr  (g1_addr),
        .needs_ram (g1_need)
    );

    bb8051_opnd_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_gen2 (
        .mode      (g2_mode),
        .op        (g2_op),
        .bank      (g_bank),
        .pointer   (ram_rdata),
        .ind_ph    (g2_ph),
        .ram_addr  (g2_addr),
        .needs_ram (g2_need)
    );

    always_comb begin
        // NOTE: every output of this block is given a default first so no latch is inferred.
        state_d  = state_q;
        cur_op_d = cur_op_q;
        ind_ph_d = ind_ph_q;
        mode1_d  = mode1_q;
        mode2_d  = mode2_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        bank_d   = bank_q;
        err_d    = err_q;
        addr_d   = addr_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        data1_d  = data1_q;
        data2_d  = data2_q;

        if (abort) begin
            state_d  = ST_IDLE;
            cur_op_d = 1'b0;
            ind_ph_d = 1'b0;
            sel1_d   = SRC_SEL_NO;
            sel2_d   = SRC_SEL_NO;
            data1_d  = '0;
            data2_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    mode1_d  = mode1;
                    mode2_d  = mode2;
                    op1_d    = op1_in;
                    op2_d    = op2_in;
                    bank_d   = reg_bank;
                    err_d    = mode_reserved(mode1) | mode_reserved(mode2);
                    cur_op_d = 1'b0;
                    ind_ph_d = 1'b0;
                    sel1_d   = direct_sel(mode1);
                    sel2_d   = direct_sel(mode2);
                    data1_d  = (mode1 == OPND_MODE_IMM) ? DATA_W'(op1_in) : '0;
                    data2_d  = (mode2 == OPND_MODE_IMM) ? DATA_W'(op2_in) : '0;
                    if (g1_need) begin
                        state_d = ST_RD;
                        addr_d  = g1_addr;
                    end else if (g2_need) begin
                        state_d  = ST_RD;
                        cur_op_d = 1'b1;
                        addr_d   = g2_addr;
                    end else begin
                        state_d = ST_GO;
                    end
                end
                ST_RD:  state_d = ST_CAP;
                ST_CAP: begin
                    if (!cur_op_q) begin
                        if (mode1_q == OPND_MODE_IND && !ind_ph_q) begin
                            state_d  = ST_RD;
                            ind_ph_d = 1'b1;
                            addr_d   = g1_addr;
                        end else begin
                            sel1_d   = SRC_SEL_CONSTANT;
                            data1_d  = ram_rdata;
                            ind_ph_d = 1'b0;
                            if (g2_need) begin
                                state_d  = ST_RD;
                                cur_op_d = 1'b1;
                                addr_d   = g2_addr;
                            end else begin
                                state_d = ST_GO;
                            end
                        end
                    end else begin
                        if (mode2_q == OPND_MODE_IND && !ind_ph_q) begin
                            state_d  = ST_RD;
                            ind_ph_d = 1'b1;
                            addr_d   = g2_addr;
                        end else begin
                            sel2_d   = SRC_SEL_CONSTANT;
                            data2_d  = ram_rdata;
                            ind_ph_d = 1'b0;
                            state_d  = ST_GO;
                        end
                    end
                end
                ST_GO:   state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q  <= ST_IDLE;
            cur_op_q <= 1'b0;
            ind_ph_q <= 1'b0;
            mode1_q  <= OPND_MODE_NONE;
            mode2_q  <= OPND_MODE_NONE;
            op1_q    <= '0;
            op2_q    <= '0;
            bank_q   <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            sel1_q   <= SRC_SEL_NO;
            sel2_q   <= SRC_SEL_NO;
            data1_q  <= '0;
            data2_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_op_q <= cur_op_d;
            ind_ph_q <= ind_ph_d;
            mode1_q  <= mode1_d;
            mode2_q  <= mode2_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            bank_q   <= bank_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
        end
    end

    assign busy      = !idle;
    assign ram_rd    = (state_q == ST_RD);
    assign alu_go    = (state_q == ST_GO);
    assign mode_err  = alu_go && err_q;
    assign ram_addr  = addr_q;
    assign src1_sel  = sel1_q;
    assign src2_sel  = sel2_q;
    assign src1_data = data1_q;
    assign src2_data = data2_q;

endmodule

// File: doc/bb8051_opnd_fetch_ctrl.md
Name: bb8051_opnd_fetch_ctrl

Overview:
Sequences operand acquisition for ALU instructions. It sits between the instruction decoder and the ALU source selector, and drives the src1/src2 select codes plus operand data.
- Accepts one request per instruction.
- Issues internal-RAM reads for direct, register (Rn) and indirect (@Ri) operands.
- Presents resolved operands, then pulses alu_go for one cycle.

Parameters:
DATA_W, 8, operand/RAM data width
ADDR_W, 8, internal RAM address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
start  in  1  decoder request; accepted only when busy=0
abort  in  1  synchronous cancel of the in-flight request
mode1  in  3  operand-1 addressing mode
mode2  in  3  operand-2 addressing mode
op1_in  in  8  instruction byte for operand 1 (imm value / direct addr / Rn,Ri index)
op2_in  in  8  instruction byte for operand 2
reg_bank  in  2  PSW RS1:RS0, sampled at start
ram_rd  out  1  RAM read strobe
ram_addr  out  ADDR_W  RAM read address
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_rd
busy  out  1  request in flight
src1_sel  out  2  to ALU source selector (SRC_SEL_ACC/CONSTANT/NO)
src2_sel  out  2  same, for operand 2
src1_data  out  DATA_W  operand-1 value on the CONSTANT path
src2_data  out  DATA_W  operand-2 value on the CONSTANT path
alu_go  out  1  one-cycle pulse: operands valid, ALU executes
mode_err  out  1  pulses with alu_go if either mode was reserved

Behaviour:
- Reset (rst=0 at a clock edge) forces:
  - state IDLE; busy=0, alu_go=0, ram_rd=0, mode_err=0
  - ram_addr=0, src*_sel=SRC_SEL_NO, src*_data=0
  - reset mid-operation discards the request with no alu_go.
- Mode codes:
  - 0 NONE → sel NO, data 0
  - 1 ACC → sel ACC, data 0
  - 2 IMM → sel CONSTANT, data = op byte
  - 3 DIR → read addr = op byte
  - 4 RN → read addr = {3'b0, bank, op[2:0]}
  - 5 IND → read Ri at {3'b0, bank, 2'b0, op[0]}, then read the returned pointer (full 8 bits)
  - 6/7 reserved → treated as NONE, sets the error flag
  - DIR/RN/IND resolve to sel CONSTANT, data = final ram_rdata.
- FSM states: IDLE, RD, CAP, GO. Register cur_op (1/2) and ind_ph (indirect phase).
  - IDLE, start=1, abort=0:
    - latch modes, op bytes and bank; busy=1
    - evaluate operand 1, then operand 2, in order
    - non-RAM modes resolve in the same cycle; first RAM-needing operand → RD; none → GO.
  - RD: ram_rd=1, ram_addr held; → CAP.
  - CAP: capture ram_rdata.
    - IND phase 1: pointer=rdata; → RD with ram_addr=pointer.
    - Otherwise store the operand, advance cur_op; next RAM operand → RD, else → GO.
  - GO: alu_go=1, mode_err as flagged; → IDLE, busy=0.
- Latency: start accepted at cycle T → alu_go at T+1+2·N, where N = total RAM reads (IND counts 2). Max N=4 → T+9.
- src*_sel/src*_data are registered. They update when an operand resolves and hold after GO until the next accepted start.
- ram_rd is high only in RD; ram_addr holds its last value otherwise.
- start while busy=1 is ignored; there is no queuing.
- abort in any state → IDLE next cycle.
  - No alu_go; ram_rd deasserts.
  - sel/data outputs return to NO/0.
  - abort with start in IDLE: abort wins, start is dropped.
- SFR decoding (addr ≥ 0x80) is downstream; this block issues the address unchanged.

Decomposition:
- Shared package bb8051_defines:
  - SRC_SEL_ACC/CONSTANT/NO codes
  - OPND_MODE_* codes
  - FSM state encodings
- One combinational sub-module, bb8051_opnd_addr_gen: inputs mode, op byte, bank, pointer, ind_ph; outputs ram_addr and needs_ram.

Test Plan:
1. mode1=ACC, mode2=IMM, op2_in=0x5A, start at T → alu_go at T+1; src1_sel=ACC, src2_sel=CONSTANT, src2_data=0x5A; ram_rd never asserted.
2. mode1=ACC, mode2=DIR, op2_in=0x30, RAM[0x30]=0xC3 → ram_rd at T+1 with addr 0x30, alu_go at T+3, src2_data=0xC3.
3. mode2=RN, op2_in=0x05, reg_bank=2'b10 → read addr 0x15; RAM[0x15]=0x77 gives src2_data=0x77.
4. mode1=IND, mode2=IND, op1_in=0x01, op2_in=0x00, bank 0; RAM[1]=0x40, RAM[0x40]=0x11, RAM[0]=0x50, RAM[0x50]=0x22 → reads 0x01, 0x40, 0x00, 0x50; alu_go at T+9; data1=0x11, data2=0x22.
5. Boundaries:
   - abort asserted in CAP of a DIR fetch → IDLE, no alu_go, sel=NO.
   - A start raised while busy is ignored.
   - rst=0 in RD clears all outputs at the next edge.
6. mode1=7, mode2=IMM 0x01 → alu_go at T+1 with mode_err=1, src1_sel=NO, src1_data=0.
